serial_word_rx: RTL
===================

SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the assembled word width in bits; legal range is N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous flush of any partially assembled word.
REQ-005 The block SHALL have port sin_valid, input, 1 bit: the serial bit is offered.
REQ-006 The block SHALL have port sin_bit, input, 1 bit: serial data, MSB of the word first.
REQ-007 The block SHALL have port sin_ready, output, 1 bit: the block can accept a serial bit.
REQ-008 The block SHALL have port out_data, output, N bits: the assembled word.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-011 The block SHALL have port bit_count, output, clog2(N+1) bits: number of bits accepted into the current partial word.

Function
REQ-012 A serial bit SHALL be accepted on a rising edge where sin_valid=1 and sin_ready=1; no other serial input is consumed.
REQ-013 Each accepted bit SHALL be shifted in as shift_reg <= {shift_reg[N-2:0], sin_bit}, and bit_count SHALL increment by 1.
REQ-014 States SHALL be IDLE (bit_count=0), SHIFT (0<bit_count<N) and FULL (completed word held, output buffer occupied); IDLE->SHIFT is taken on the first accept.
REQ-015 A word SHALL complete on the Nth accepted bit; the completed value is {shift_reg[N-2:0], sin_bit} at that edge.
REQ-016 On completion, if out_valid=0 or out_ready=1 in that cycle: out_data SHALL load the completed word, out_valid SHALL be 1 from the next cycle, bit_count SHALL become 0, and the state SHALL become IDLE (0 cycles of bubble).
REQ-017 On completion with out_valid=1 and out_ready=0, the completed word SHALL be held internally and the state SHALL become FULL.
REQ-018 sin_ready SHALL be 0 in FULL and 1 in IDLE and SHIFT.
REQ-019 In FULL, on an edge with out_ready=1: out_data SHALL load the held word, out_valid SHALL stay 1, and the state SHALL become IDLE with bit_count=0.
REQ-020 Otherwise, on an edge with out_valid=1 and out_ready=1, out_valid SHALL become 0; out_data SHALL keep its last value.
REQ-021 out_data and out_valid SHALL NOT change while out_valid=1 and out_ready=0.
REQ-022 clear=1 SHALL force IDLE with bit_count=0 and discard any partial or held word, while leaving out_data/out_valid untouched; out_ready handling in the same cycle still applies.
REQ-023 If clear coincides with a bit accept or a completion, clear SHALL win and the bit or word SHALL be discarded.
REQ-024 Gaps in sin_valid SHALL NOT affect the partial word; there is no timeout.

Reset
REQ-025 reset=0 SHALL asynchronously force: state IDLE, shift_reg=0, held word=0, bit_count=0, out_data=0, out_valid=0, sin_ready=1.
REQ-026 Reset asserted mid-word or in FULL SHALL discard all words; after release, the first accepted bit SHALL start a new word.

Verification (N=8)
REQ-027 The bench SHALL cover: bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1 -> out_valid=1 the cycle after the 8th accept, out_data=0xA5, then out_valid=0 next cycle.
REQ-028 The bench SHALL cover: 0x3C then 0xC3 back-to-back with out_ready=0 -> out_data=0x3C held, sin_ready=0 after the 16th bit; then out_ready=1 for one cycle -> out_data=0xC3, out_valid=1, sin_ready=1.
REQ-029 The bench SHALL cover: 4 bits accepted, clear pulse, then 0xFF -> bit_count=0 after the clear, out_data=0xFF, no stale bits.
REQ-030 The bench SHALL cover: sin_valid toggled every other cycle while sending 0x81 -> out_data=0x81, completing 8 accepts after the first, not 8 cycles.
REQ-031 The bench SHALL cover: reset pulled low after 5 bits of 0x5A, then 0x0F sent -> out_data=0x0F, out_valid=0 during reset.
REQ-032 The bench SHALL cover: completion on the same edge as out_ready=1 with an old word present -> the new word replaces the old, out_valid stays 1, no state FULL.

Source files
------------

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word assembler, MSB first, with a one-word
// skid buffer so a completed word can wait for a stalled consumer.
module serial_word_rx #(
  parameter int N = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     sin_valid,
  input  logic                     sin_bit,
  output logic                     sin_ready,
  output logic [N-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N+1)-1:0]   bit_count
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  held_q, held_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          last_bit;
  logic [N-1:0]  word;

  assign sin_ready = (state_q != FULL);
  assign accept    = sin_valid & sin_ready;
  assign last_bit  = (cnt_q == CW'(N-1));
  assign word      = {shift_q[N-2:0], sin_bit};

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign bit_count = cnt_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    held_d  = held_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (clear) begin
      // flush wins over any accept or completion this cycle
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      held_d  = '0;
      if (valid_q && out_ready) valid_d = 1'b0;
    end else if (state_q == FULL) begin
      if (out_ready) begin
        data_d  = held_q;
        valid_d = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      if (valid_q && out_ready) valid_d = 1'b0;
      if (accept) begin
        shift_d = word;
        cnt_d   = cnt_q + 1'b1;
        state_d = SHIFT;
        if (last_bit) begin
          cnt_d = '0;
          if (!valid_q || out_ready) begin
            data_d  = word;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            held_d  = word;
            state_d = FULL;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      held_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      held_q  <= held_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
